mem_port_arbiter: RTL

- Shares one single-ported, variable-latency backing memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Replaces the dual-read-port unified memory path.
- Data accesses win by default. A starvation counter guarantees fetch progress.
- Per-requester busy outputs feed the pipeline stall logic (PC write stall, IF/ID bubble).

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - arbiter state encoding and shared access width constants
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SRV_IF = 2'd1,
    ARB_SRV_DM = 2'd2
  } arb_state_t;

  localparam logic [3:0] WIDTH_BYTE = 4'd1;
  localparam logic [3:0] WIDTH_HALF = 4'd2;
  localparam logic [3:0] WIDTH_WORD = 4'd4;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and data requesters
// Data wins by default; a saturating starvation counter forces a fetch grant at STARVE_LIMIT.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  output logic                  if_busy,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [3:0]            dm_width,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_valid,
  output logic                  dm_busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_width,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_t              state, state_d;
  logic [STARVE_CNT_W-1:0] starve_cnt, starve_d;

  logic                  mem_req_d, mem_we_d;
  logic [3:0]            mem_width_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_d, dm_rdata_d;
  logic                  if_valid_d, dm_valid_d;
  logic                  grant_dm;

  assign grant_dm = dm_req && (!if_req || (starve_cnt < STARVE_MAX));

  assign if_busy = if_req & ~if_valid;
  assign dm_busy = dm_req & ~dm_valid;

  always_comb begin
    state_d     = state;
    starve_d    = starve_cnt;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_width_d = mem_width;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;

    case (state)
      ARB_IDLE: begin
        // mem_ack seen here belongs to nothing we issued and is dropped
        if (grant_dm) begin
          state_d     = ARB_SRV_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_width_d = dm_width;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (!if_req) begin
            starve_d = '0;
          end else if (starve_cnt < STARVE_MAX) begin
            starve_d = starve_cnt + 1'b1;
          end
        end else if (if_req) begin
          state_d     = ARB_SRV_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_width_d = WIDTH_WORD;
          mem_addr_d  = if_addr;
          starve_d    = '0;
        end
      end

      ARB_SRV_IF: begin
        if (mem_ack) begin
          state_d    = ARB_IDLE;
          mem_req_d  = 1'b0;
          if_valid_d = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end

      ARB_SRV_DM: begin
        if (mem_ack) begin
          state_d    = ARB_IDLE;
          mem_req_d  = 1'b0;
          dm_valid_d = 1'b1;
          // stores keep the last load result visible
          if (!mem_we) begin
            dm_rdata_d = mem_rdata;
          end
        end
      end

      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_width  <= 4'd0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
    end else begin
      state      <= state_d;
      starve_cnt <= starve_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_width  <= mem_width_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      if_rdata   <= if_rdata_d;
      dm_rdata   <= dm_rdata_d;
      if_valid   <= if_valid_d;
      dm_valid   <= dm_valid_d;
    end
  end

endmodule
